// File: rtl/mod_exponentiation_if.sv
// rtl/mod_exponentiation_if.sv - start/done request bundle for the modular-exponentiation engine
interface mod_exponentiation_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] exponent;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] result;
  logic             done;
  logic             busy;
  logic             err;

  modport master (
    output start, base, exponent, p,
    input  result, done, busy, err
  );

  modport slave (
    input  start, base, exponent, p,
    output result, done, busy, err
  );
endinterface

// File: rtl/mod_exponentiation.sv
// rtl/mod_exponentiation.sv - base^exponent mod p via right-to-left square-and-multiply over a bit-serial mulmod
// MODEXP_EARLY_EXIT_EN: stop once the remaining exponent is zero instead of always walking all WIDTH bits.
module mod_exponentiation #(
  parameter int WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  mod_exponentiation_if.slave  bus_io
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_REDUCE, S_EXAM, S_MUL, S_SQR, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] e_q, e_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             err_q, err_d;
  logic [CW-1:0]    mcnt_q, mcnt_d;
  logic [CW-1:0]    kcnt_q, kcnt_d;

  logic [WIDTH:0]   p_ext, mult, dbl, dbl_red, sum;
  logic [WIDTH-1:0] acc_nxt;
  logic             mul_last, in_mul, exam_term;

  // One interleaved step: double-and-reduce, then add the selected multiplicand and reduce.
  always_comb begin
    p_ext   = {1'b0, p_q};
    mult    = (state_q == S_REDUCE) ? {{WIDTH{1'b0}}, 1'b1} : {1'b0, b_q};
    dbl     = {acc_q, 1'b0};
    dbl_red = (dbl >= p_ext) ? (dbl - p_ext) : dbl;
    sum     = dbl_red + (a_q[WIDTH-1] ? mult : '0);
    acc_nxt = (sum >= p_ext) ? WIDTH'(sum - p_ext) : sum[WIDTH-1:0];
  end

  assign mul_last = (mcnt_q == CW'(WIDTH - 1));
  assign in_mul   = (state_q == S_REDUCE) || (state_q == S_MUL) || (state_q == S_SQR);

`ifdef MODEXP_EARLY_EXIT_EN
  assign exam_term = (e_q == '0);
`else
  assign exam_term = (kcnt_q == CW'(WIDTH));
`endif

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    acc_d    = acc_q;
    b_d      = b_q;
    r_d      = r_q;
    e_d      = e_q;
    p_d      = p_q;
    result_d = result_q;
    err_d    = err_q;
    mcnt_d   = mcnt_q;
    kcnt_d   = kcnt_q;

    if (in_mul) begin
      acc_d  = acc_nxt;
      a_d    = a_q << 1;
      mcnt_d = mcnt_q + CW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (bus_io.start) begin
          e_d   = bus_io.exponent;
          p_d   = bus_io.p;
          err_d = 1'b0;
          if (bus_io.p < WIDTH'(2)) begin
            result_d = '0;
            err_d    = 1'b1;
            state_d  = S_DONE;
          end else begin
            r_d     = WIDTH'(1);
            a_d     = bus_io.base;
            acc_d   = '0;
            mcnt_d  = '0;
            kcnt_d  = '0;
            state_d = S_REDUCE;
          end
        end
      end
      S_REDUCE: begin
        if (mul_last) begin
          b_d     = acc_nxt;
          acc_d   = '0;
          mcnt_d  = '0;
          state_d = S_EXAM;
        end
      end
      S_EXAM: begin
        if (exam_term) begin
          result_d = r_q;
          state_d  = S_DONE;
        end else if (e_q[0]) begin
          a_d     = r_q;
          state_d = S_MUL;
        end else begin
          a_d     = b_q;
          state_d = S_SQR;
        end
      end
      S_MUL: begin
        if (mul_last) begin
          r_d     = acc_nxt;
          a_d     = b_q;
          acc_d   = '0;
          mcnt_d  = '0;
          state_d = S_SQR;
        end
      end
      S_SQR: begin
        if (mul_last) begin
          b_d     = acc_nxt;
          e_d     = e_q >> 1;
          kcnt_d  = kcnt_q + CW'(1);
          acc_d   = '0;
          mcnt_d  = '0;
          state_d = S_EXAM;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      acc_q    <= '0;
      b_q      <= '0;
      r_q      <= '0;
      e_q      <= '0;
      p_q      <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      mcnt_q   <= '0;
      kcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      r_q      <= r_d;
      e_q      <= e_d;
      p_q      <= p_d;
      result_q <= result_d;
      err_q    <= err_d;
      mcnt_q   <= mcnt_d;
      kcnt_q   <= kcnt_d;
    end
  end

  assign bus_io.result = result_q;
  assign bus_io.err    = err_q;
  assign bus_io.done   = (state_q == S_DONE);
  assign bus_io.busy   = (state_q != S_IDLE);
endmodule
